if_prefetch_queue: RTL
======================

Name: if_prefetch_queue

Overview:
- Instruction prefetch stage between the word-addressed instruction ROM and the fetch/decode pipeline buffer.
- Owns the fetch PC and issues one ROM address per cycle.
- Captures each returned instruction with its PC into a small FIFO and presents the head to decode with a valid/stall handshake.
- Branch/jump redirects flush all prefetched entries and restart fetch at the target PC.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_W, 8, program counter width (word address)
- INSTR_W, 32, instruction width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- redirect  in  1  branch/jump taken this cycle; flush queue and reload PC
- redirect_pc  in  PC_W  target PC for redirect
- stall  in  1  decode cannot accept the head entry this cycle
- rom_addr  out  PC_W  combinational ROM address; equals fetch_pc
- rom_instr  in  INSTR_W  combinational ROM data for rom_addr, same cycle
- out_valid  out  1  head entry present
- out_pc  out  PC_W  PC of head instruction
- out_next_pc  out  PC_W  out_pc + 1, modulo 2^PC_W
- out_instr  out  INSTR_W  head instruction
- count  out  clog2(DEPTH)+1  current occupancy (debug/verification)

Behaviour:
- State: fetch_pc, FIFO storage of DEPTH {pc, instr} entries, wr_ptr, rd_ptr, count.
- Reset (async, rst=1): fetch_pc=0, wr_ptr=rd_ptr=0, count=0.
  - Outputs during and after reset: out_valid=0, out_pc=0, out_next_pc=1, out_instr=0, rom_addr=0.
  - Storage contents need not be cleared.
- Handshake:
  - deq = out_valid & ~stall.
  - enq = (count < DEPTH) | deq.
  - Enqueue is allowed when full if a dequeue happens in the same cycle.
- Enqueue:
  - Writes {fetch_pc, rom_instr} at wr_ptr.
  - wr_ptr += 1 modulo DEPTH.
  - fetch_pc += 1 modulo 2^PC_W; 255 wraps to 0 with PC_W=8.
- Dequeue: rd_ptr += 1 modulo DEPTH.
- count update: count += enq - deq. Both asserted → count unchanged.
- Head outputs:
  - Driven combinationally from the entry at rd_ptr.
  - out_valid = (count != 0).
  - When out_valid=0, out_pc/out_instr are don't-care, except after reset (zeros, as above).
- Latency:
  - Instruction at PC p is enqueued in the cycle rom_addr=p.
  - It is visible at the head, with out_valid=1, the following cycle when the queue was empty.
  - First valid output appears in the first cycle after reset deassertion edge + 1 clock.
- Redirect (highest priority, overrides enq/deq):
  - Next edge: wr_ptr=rd_ptr=0, count=0, fetch_pc=redirect_pc.
  - rom_instr in the redirect cycle is discarded.
  - out_valid=0 for exactly one cycle after redirect.
  - The target instruction is at the head the following cycle.
  - A head entry presented in the redirect cycle is treated as not consumed, even if stall=0; the pipeline squashes it.
- Back-to-back redirects: each redirect reloads fetch_pc; only the last one takes effect.
- Stall while full:
  - fetch_pc holds and rom_addr is stable.
  - No entries are lost or duplicated.
- Steady flow (stall=0, no redirect): count settles at 1, one instruction per cycle, PCs consecutive.
- Reset asserted mid-operation: immediate clear of all state regardless of redirect/stall.

Decomposition:
- Shared definitions package gains:
  - PC_W and INSTR_W constants (the existing ProgramCounter/Instruction typedefs).
  - A packed struct FetchEntry {ProgramCounter pc; Instruction instr;}.
  - A packed struct for the queue head outputs, so the fetch/decode buffer can take one bus.
- One sub-module is natural: prefetch_fifo.
  - Generic DEPTH x FetchEntry circular buffer with enq/deq/flush and count.
- The top handles fetch_pc, redirect priority and the handshake.

Test Plan:
- Reset then stall=0, ROM[i]=0x1000_0000+i:
  - out_valid rises one cycle after reset release.
  - out_pc 0,1,2,3… with matching instrs, one per cycle; count stays 1.
- stall=1 held 6 cycles from reset:
  - count 1,2,3,4,4,4; rom_addr stops at 4.
  - Release stall → heads PC 0..3 then 4, no gaps or duplicates.
- Full queue (count=4) with stall=0 for one cycle:
  - Simultaneous enq/deq, count stays 4, PC 4 enqueued, head advances to PC 1.
- redirect=1, redirect_pc=0x40 while count=3:
  - Next cycle out_valid=0, count=0, rom_addr=0x40.
  - Following cycle out_pc=0x40, out_next_pc=0x41.
- Redirect to 0xFE, stall=0:
  - Head PCs 0xFE, 0xFF, 0x00, 0x01.
  - out_next_pc for 0xFF is 0x00.
- rst pulsed asynchronously mid-cycle with count=2 and redirect=1:
  - Outputs clear immediately (out_valid=0, rom_addr=0) before the next clock edge.
  - Fetch restarts from PC 0.

Source files
------------

// File: rtl/if_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: PC/instruction words,
// the stored fetch entry, and the head bus handed to the fetch/decode buffer.
package if_prefetch_queue_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PC_W    = 8;
  localparam int DEF_INSTR_W = 32;

  typedef logic [DEF_PC_W-1:0]    ProgramCounter;
  typedef logic [DEF_INSTR_W-1:0] Instruction;

  typedef struct packed {
    ProgramCounter pc;
    Instruction    instr;
  } FetchEntry;

  typedef struct packed {
    logic          valid;
    ProgramCounter pc;
    ProgramCounter next_pc;
    Instruction    instr;
  } QueueHead;

  // Occupancy counter must represent DEPTH itself, hence the extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic QueueHead make_head(input logic valid, input FetchEntry e);
    QueueHead h;
    h.valid   = valid;
    h.pc      = valid ? e.pc : {DEF_PC_W{1'b0}};
    h.instr   = valid ? e.instr : {DEF_INSTR_W{1'b0}};
    h.next_pc = h.pc + {{(DEF_PC_W-1){1'b0}}, 1'b1};
    return h;
  endfunction

endpackage

// File: rtl/if_prefetch_queue_prefetch_fifo.sv
// Generic DEPTH-entry circular buffer with enqueue, dequeue, flush and an
// occupancy count. Flush wins over enqueue/dequeue in the same cycle.
module if_prefetch_queue_prefetch_fifo
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_PC_W + DEF_INSTR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq,
  input  logic                    deq,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            rdata,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, queues {pc, instr} pairs read
// from the ROM, and presents the oldest one to decode with a valid/stall handshake.
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [PC_W-1:0]         redirect_pc,
  input  logic                    stall,
  output logic [PC_W-1:0]         rom_addr,
  input  logic [INSTR_W-1:0]      rom_instr,
  output logic                    out_valid,
  output logic [PC_W-1:0]         out_pc,
  output logic [PC_W-1:0]         out_next_pc,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = PC_W + INSTR_W;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_s;
  logic [EW-1:0]   head_s;
  logic            valid_s;
  logic            enq_s;
  logic            deq_s;

  // Redirect squashes the head (not consumed) and discards this cycle's ROM word.
  always_comb begin
    valid_s = (count_s != {CW{1'b0}});
    if (redirect) begin
      deq_s      = 1'b0;
      enq_s      = 1'b0;
      fetch_pc_d = redirect_pc;
    end else begin
      deq_s = valid_s & ~stall;
      enq_s = (count_s < DEPTH_C) | deq_s;
      if (enq_s) begin
        fetch_pc_d = fetch_pc_q + PC_ONE;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= {PC_W{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  if_prefetch_queue_prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .enq   (enq_s),
    .deq   (deq_s),
    .wdata ({fetch_pc_q, rom_instr}),
    .rdata (head_s),
    .count (count_s)
  );

  // Head is forced to zero when empty so reset yields clean, defined outputs.
  always_comb begin
    out_valid = valid_s;
    if (valid_s) begin
      out_pc    = head_s[EW-1 -: PC_W];
      out_instr = head_s[INSTR_W-1:0];
    end else begin
      out_pc    = {PC_W{1'b0}};
      out_instr = {INSTR_W{1'b0}};
    end
    out_next_pc = out_pc + PC_ONE;
  end

  assign rom_addr = fetch_pc_q;
  assign count    = count_s;

endmodule
